mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all address ports.
REQ-002 Parameter DATA_W, default 32, data width of all data ports.
REQ-003 Parameter TIMEOUT, default 15, maximum cycles waiting for mem_ready before an error completion; valid range 1..255.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 i_req, i_addr[ADDR_W]  in  instruction-fetch request and address; held stable until i_ack.
REQ-007 i_rdata[DATA_W], i_ack, i_err  out  fetch data, one-cycle completion pulse, timeout flag.
REQ-008 d_req, d_wen, d_addr[ADDR_W], d_wdata[DATA_W]  in  data request, write enable (1 = write), address, write data; held stable until d_ack.
REQ-009 d_rdata[DATA_W], d_ack, d_err  out  data read result, one-cycle completion pulse, timeout flag.
REQ-010 mem_rd, mem_wr, mem_addr[ADDR_W], mem_wdata[DATA_W]  out  unified memory command, all registered.
REQ-011 mem_rdata[DATA_W], mem_ready  in  memory read data and one-cycle done strobe.

Function
REQ-012 FSM states: IDLE, BUSY_I, BUSY_D, RESP.
REQ-013 In IDLE, with no request pending: remain in IDLE; mem_rd and mem_wr low.
REQ-014 In IDLE, with one request pending: grant it the following cycle (enter BUSY_I or BUSY_D).
REQ-015 In IDLE, with both requests pending: grant the port not granted last (round-robin via a last_grant bit).
REQ-016 On grant, register the address, write data and command; during BUSY, mem_rd = 1 for a fetch or data read, and mem_wr = 1 for a data write.
REQ-017 Command outputs stay constant throughout BUSY, regardless of requester inputs.
REQ-018 BUSY exits on mem_ready; mem_ready arriving in the first BUSY cycle is legal.
REQ-019 On mem_ready: capture mem_rdata into the granted port's rdata register (writes leave d_rdata unchanged), drop mem_rd and mem_wr next cycle, enter RESP.
REQ-020 RESP lasts exactly one cycle and asserts only the granted port's ack.
REQ-021 rdata is valid in the ack cycle and holds until that port's next completion.
REQ-022 Requesters drop req in the cycle after ack; requests are sampled only in IDLE, so RESP ignores req and returns to IDLE.
REQ-023 Minimum latency: req high in IDLE at cycle 0, mem command in cycle 1, mem_ready in cycle 1, ack in cycle 2.
REQ-024 A wait counter (8 bits) clears on grant and increments each BUSY cycle without mem_ready.
REQ-025 When the wait counter reaches TIMEOUT: enter RESP with the port's err = 1 and rdata unchanged.
REQ-026 err is valid only while ack is high; otherwise 0.
REQ-027 mem_ready outside BUSY is ignored.
REQ-028 last_grant updates on every grant, including grants that end in timeout.
REQ-029 mem_rd and mem_wr are never asserted together; ack outputs are never asserted together.

Reset
REQ-030 rst high at a clock edge forces: state IDLE, mem_rd = mem_wr = 0, mem_addr = mem_wdata = 0, acks = errs = 0, rdata registers = 0, wait counter = 0, last_grant = I.
REQ-031 Because last_grant resets to I, the data port wins the first contention.
REQ-032 Reset during BUSY or RESP abandons the transaction with no ack; the requester re-issues.
REQ-033 A req held high through reset is granted in the second cycle after rst falls (one IDLE cycle, then BUSY).

Structure
REQ-034 A shared package holds the FSM state enum, default widths and the TIMEOUT default, for reuse by the CPU stall logic.
REQ-035 One sub-module, arb_rr2, is natural: a two-way round-robin grant with a last_grant register.
REQ-036 The FSM, wait counter and datapath registers stay in mem_arbiter.

Verification
REQ-037 Single fetch: i_req = 1, i_addr = 0x10, mem_ready 3 cycles after mem_rd rises with mem_rdata = 0x00500093 -> one i_ack pulse, i_rdata = 0x00500093, i_err = 0.
REQ-038 Data write: d_wen = 1, d_addr = 0x1000, d_wdata = 0xDEADBEEF -> mem_wr = 1 with that address and data held until mem_ready, d_ack pulse, d_rdata unchanged.
REQ-039 Contention after reset: i_req and d_req held high, zero-wait memory -> grants alternate D, I, D, I; each transaction takes 3 cycles including IDLE.
REQ-040 Timeout: d_req read, mem_ready never asserted, TIMEOUT = 15 -> d_ack and d_err high 16 cycles after grant, mem_rd low afterward.
REQ-041 Reset mid-BUSY: assert rst during the 2nd BUSY cycle -> next cycle all outputs reset, no ack; a later request completes normally.
REQ-042 Stray mem_ready asserted in IDLE -> no ack, no state change.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// default widths and the wait-timeout default (also used by CPU stall logic).
package mem_arbiter_pkg;
  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 15;
  localparam int WAIT_W      = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_RESP   = 2'd3
  } arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and unified memory.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              i_ack;
  logic              i_err;
  logic              d_req;
  logic              d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              d_err;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  // Handshake: a requester holds req and its payload stable until a one-cycle
  // ack (err qualifies ack only); the arbiter holds mem_rd/mem_wr and payload
  // stable until a one-cycle mem_ready, which is ignored outside a command.
  modport slave (
    input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
           mem_rd, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
           mem_rd, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter_rr2.sv
// Two-way round-robin grant: on a tie, the port not granted last wins.
module arb_rr2 (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  logic i_req_i,
  input  logic i_req_d,
  output logic o_gnt_valid,
  output logic o_gnt_d
);
  logic r_last_d;

  always_comb begin
    o_gnt_valid = i_req_i | i_req_d;
    o_gnt_d     = i_req_d & (~i_req_i | ~r_last_d);
  end

  // Resetting to "fetch granted last" lets the data port win the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_d <= 1'b0;
    end else if (i_en && o_gnt_valid) begin
      r_last_d <= o_gnt_d;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and data requests onto one registered memory command port,
// with a wait-cycle timeout that completes the transaction with err.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus,
  output arb_state_t   o_state
);
  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

  arb_state_t        r_state;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              r_i_ack;
  logic              r_i_err;
  logic              r_d_ack;
  logic              r_d_err;
  logic [WAIT_W-1:0] r_wait_cnt;

  logic              w_idle;
  logic              w_gnt_valid;
  logic              w_gnt_d;
  logic [WAIT_W-1:0] w_wait_next;
  logic              w_timeout;

  assign w_idle      = (r_state == ST_IDLE);
  assign w_wait_next = r_wait_cnt + WAIT_W'(1);
  assign w_timeout   = (w_wait_next == TIMEOUT_CNT);

  arb_rr2 u_rr (
    .clk         (clk),
    .rst         (rst),
    .i_en        (w_idle),
    .i_req_i     (bus.i_req),
    .i_req_d     (bus.d_req),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_d     (w_gnt_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_i_ack     <= 1'b0;
      r_i_err     <= 1'b0;
      r_d_ack     <= 1'b0;
      r_d_err     <= 1'b0;
      r_wait_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_valid) begin
            r_wait_cnt <= '0;
            if (w_gnt_d) begin
              r_state     <= ST_BUSY_D;
              r_mem_addr  <= bus.d_addr;
              r_mem_wdata <= bus.d_wdata;
              r_mem_rd    <= ~bus.d_wen;
              r_mem_wr    <= bus.d_wen;
            end else begin
              r_state    <= ST_BUSY_I;
              r_mem_addr <= bus.i_addr;
              r_mem_rd   <= 1'b1;
              r_mem_wr   <= 1'b0;
            end
          end
        end
        ST_BUSY_I, ST_BUSY_D: begin
          if (!bus.mem_ready) begin
            r_wait_cnt <= w_wait_next;
          end
          // A real mem_ready beats a timeout landing in the same cycle.
          if (bus.mem_ready || w_timeout) begin
            r_state  <= ST_RESP;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            if (r_state == ST_BUSY_I) begin
              r_i_ack <= 1'b1;
              r_i_err <= ~bus.mem_ready;
              if (bus.mem_ready) r_i_rdata <= bus.mem_rdata;
            end else begin
              r_d_ack <= 1'b1;
              r_d_err <= ~bus.mem_ready;
              if (bus.mem_ready && r_mem_rd) r_d_rdata <= bus.mem_rdata;
            end
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
          r_i_ack <= 1'b0;
          r_i_err <= 1'b0;
          r_d_ack <= 1'b0;
          r_d_err <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_rd    = r_mem_rd;
  assign bus.mem_wr    = r_mem_wr;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.i_rdata   = r_i_rdata;
  assign bus.i_ack     = r_i_ack;
  assign bus.i_err     = r_i_err;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.d_ack     = r_d_ack;
  assign bus.d_err     = r_d_err;
  assign o_state       = r_state;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: memory responder, per-port response
// scoreboards and a memory-command scoreboard.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  arb_state_t state;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (state)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [32:0] exp_i_q[$];
  logic [32:0] exp_d_q[$];
  logic [65:0] exp_cmd_q[$];
  int          i_ack_t[$];
  int          d_ack_t[$];
  int          cyc_cnt = 0;
  bit          mon_en = 1'b0;
  bit          mem_resp_on = 1'b1;
  bit          stray = 1'b0;
  int          mem_delay = 0;
  logic [31:0] mem_model[logic [31:0]];
  logic [31:0] last_i_rdata = '0;
  logic [31:0] last_d_rdata = '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return ~a;
  endfunction

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // ---------------- memory responder + command checker ----------------
  initial begin
    int          cyc;
    bit          prev_cmd;
    logic [65:0] cur_cmd;
    logic [65:0] seen;
    cyc = 0;
    prev_cmd = 1'b0;
    cur_cmd = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_ready = stray;
      if (bus.mem_rd === 1'b1 || bus.mem_wr === 1'b1) begin
        seen = {bus.mem_rd, bus.mem_wr, bus.mem_addr, (bus.mem_rd ? 32'h0 : bus.mem_wdata)};
        if (!prev_cmd) begin
          if (exp_cmd_q.size() == 0) begin
            cur_cmd = '0;
            check("cmd_unexpected", seen, cur_cmd);
          end else begin
            cur_cmd = exp_cmd_q.pop_front();
            check("mem_cmd", seen, cur_cmd);
          end
        end else begin
          check("mem_cmd_hold", seen, cur_cmd);
        end
        prev_cmd = 1'b1;
        if (mem_resp_on && cyc == mem_delay) begin
          bus.mem_ready = 1'b1;
          if (bus.mem_rd) bus.mem_rdata = mem_read(bus.mem_addr);
          else mem_model[bus.mem_addr] = bus.mem_wdata;
          cyc = 0;
        end else begin
          bus.mem_rdata = $urandom;
          cyc++;
        end
      end else begin
        prev_cmd = 1'b0;
        cyc = 0;
        bus.mem_rdata = $urandom;
      end
    end
  end

  // ---------------- response monitor ----------------
  initial begin
    forever begin
      @(posedge clk); #1;
      if (mon_en) begin
        check("err_gate", {bus.i_err & ~bus.i_ack, bus.d_err & ~bus.d_ack}, 2'b00);
        if (bus.i_ack === 1'b1 || bus.d_ack === 1'b1)
          check("ack_onehot", bus.i_ack ^ bus.d_ack, 1'b1);
        if (bus.i_ack === 1'b1) begin
          i_ack_t.push_back(cyc_cnt);
          if (exp_i_q.size() == 0) check("i_ack_unexp", bus.i_ack, 1'b0);
          else check("i_resp", {bus.i_err, bus.i_rdata}, exp_i_q.pop_front());
        end
        if (bus.d_ack === 1'b1) begin
          d_ack_t.push_back(cyc_cnt);
          if (exp_d_q.size() == 0) check("d_ack_unexp", bus.d_ack, 1'b0);
          else check("d_resp", {bus.d_err, bus.d_rdata}, exp_d_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_i(input logic [31:0] addr, output int lat);
    lat = -1;
    bus.i_req  = 1'b1;
    bus.i_addr = addr;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (bus.i_ack === 1'b1) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) check("i_ack_wait", bus.i_ack, 1'b1);
    @(posedge clk); #1;
    bus.i_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_d(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat);
    lat = -1;
    bus.d_req   = 1'b1;
    bus.d_wen   = wen;
    bus.d_addr  = addr;
    bus.d_wdata = wdata;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (bus.d_ack === 1'b1) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) check("d_ack_wait", bus.d_ack, 1'b1);
    @(posedge clk); #1;
    bus.d_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_state"}, state, ST_IDLE);
    check({tag, "_cmd"}, {bus.mem_rd, bus.mem_wr, bus.mem_addr, bus.mem_wdata}, 66'd0);
    check({tag, "_resp"}, {bus.i_ack, bus.d_ack, bus.i_err, bus.d_err, bus.i_rdata, bus.d_rdata},
          68'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int          lat;
    int          s;
    int          dly;
    bit          port_d;
    bit          wen;
    logic [31:0] a;
    logic [31:0] wd;

    rst = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_wen = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("reset");
    mon_en = 1'b1;
    rst = 1'b0;

    // Single fetch, memory answers 3 cycles after mem_rd rises
    mem_model[32'h10] = 32'h0050_0093;
    mem_delay = 3;
    exp_cmd_q.push_back({1'b1, 1'b0, 32'h10, 32'h0});
    exp_i_q.push_back({1'b0, 32'h0050_0093});
    run_i(32'h10, lat);
    check("fetch_lat", lat, 5);
    last_i_rdata = 32'h0050_0093;

    // Data write held for two wait cycles; d_rdata must not move
    mem_delay = 2;
    exp_cmd_q.push_back({1'b0, 1'b1, 32'h1000, 32'hDEAD_BEEF});
    exp_d_q.push_back({1'b0, last_d_rdata});
    run_d(1'b1, 32'h1000, 32'hDEAD_BEEF, lat);
    check("write_lat", lat, 4);

    // Zero-wait read-back at minimum latency
    mem_delay = 0;
    exp_cmd_q.push_back({1'b1, 1'b0, 32'h1000, 32'h0});
    exp_d_q.push_back({1'b0, 32'hDEAD_BEEF});
    run_d(1'b0, 32'h1000, 32'h0, lat);
    check("read_lat", lat, 2);
    last_d_rdata = 32'hDEAD_BEEF;

    // Timeout: memory never answers
    mem_resp_on = 1'b0;
    exp_cmd_q.push_back({1'b1, 1'b0, 32'h2000, 32'h0});
    exp_d_q.push_back({1'b1, last_d_rdata});
    run_d(1'b0, 32'h2000, 32'h0, lat);
    check("timeout_lat", lat, TO + 1);
    check("timeout_cmd_low", {bus.mem_rd, bus.mem_wr}, 2'b00);
    mem_resp_on = 1'b1;

    // Stray mem_ready while idle
    stray = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("stray_state", state, ST_IDLE);
      check("stray_ack", {bus.i_ack, bus.d_ack}, 2'b00);
      check("stray_rdata", {bus.i_rdata, bus.d_rdata}, {last_i_rdata, last_d_rdata});
    end
    stray = 1'b0;
    @(posedge clk); #1;

    // Reset in the second BUSY cycle abandons the read
    mem_resp_on = 1'b0;
    exp_cmd_q.push_back({1'b1, 1'b0, 32'h3000, 32'h0});
    bus.d_req = 1'b1; bus.d_wen = 1'b0; bus.d_addr = 32'h3000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midbusy_state", state, ST_BUSY_D);
    rst = 1'b1;
    bus.d_req = 1'b0;
    @(posedge clk); #1;
    check_reset_outs("midbusy_rst");
    rst = 1'b0;
    mem_resp_on = 1'b1;
    last_i_rdata = '0;
    last_d_rdata = '0;
    mem_delay = 1;
    exp_cmd_q.push_back({1'b1, 1'b0, 32'h24, 32'h0});
    exp_i_q.push_back({1'b0, mem_read(32'h24)});
    run_i(32'h24, lat);
    check("after_rst_lat", lat, 3);
    last_i_rdata = mem_read(32'h24);

    // Contention from reset: data wins first, then strict alternation
    mem_delay = 0;
    rst = 1'b1;
    i_ack_t.delete();
    d_ack_t.delete();
    exp_cmd_q.push_back({1'b1, 1'b0, 32'h40, 32'h0});
    exp_cmd_q.push_back({1'b1, 1'b0, 32'h80, 32'h0});
    exp_cmd_q.push_back({1'b1, 1'b0, 32'h44, 32'h0});
    exp_cmd_q.push_back({1'b1, 1'b0, 32'h84, 32'h0});
    exp_d_q.push_back({1'b0, mem_read(32'h40)});
    exp_d_q.push_back({1'b0, mem_read(32'h44)});
    exp_i_q.push_back({1'b0, mem_read(32'h80)});
    exp_i_q.push_back({1'b0, mem_read(32'h84)});
    s = 0;
    fork
      begin
        int l0;
        run_d(1'b0, 32'h40, 32'h0, l0);
        run_d(1'b0, 32'h44, 32'h0, l0);
      end
      begin
        int l1;
        run_i(32'h80, l1);
        run_i(32'h84, l1);
      end
      begin
        @(posedge clk); #1;
        s = cyc_cnt;
        rst = 1'b0;
      end
    join
    check("cont_n", d_ack_t.size() * 16 + i_ack_t.size(), 34);
    if (d_ack_t.size() == 2 && i_ack_t.size() == 2) begin
      check("cont_d0", d_ack_t[0] - s, 2);
      check("cont_i0", i_ack_t[0] - s, 5);
      check("cont_d1", d_ack_t[1] - s, 8);
      check("cont_i1", i_ack_t[1] - s, 11);
    end
    last_i_rdata = mem_read(32'h84);
    last_d_rdata = mem_read(32'h44);

    // Randomised sequential traffic
    for (int k = 0; k < 12; k++) begin
      port_d    = 1'($urandom_range(0, 1));
      wen       = 1'($urandom_range(0, 1));
      dly       = $urandom_range(0, 4);
      a         = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      wd        = $urandom;
      mem_delay = dly;
      if (!port_d) begin
        exp_cmd_q.push_back({1'b1, 1'b0, a, 32'h0});
        exp_i_q.push_back({1'b0, mem_read(a)});
        last_i_rdata = mem_read(a);
        run_i(a, lat);
      end else if (wen) begin
        exp_cmd_q.push_back({1'b0, 1'b1, a, wd});
        exp_d_q.push_back({1'b0, last_d_rdata});
        run_d(1'b1, a, wd, lat);
      end else begin
        exp_cmd_q.push_back({1'b1, 1'b0, a, 32'h0});
        exp_d_q.push_back({1'b0, mem_read(a)});
        last_d_rdata = mem_read(a);
        run_d(1'b0, a, 32'h0, lat);
      end
      check("rand_lat", lat, dly + 2);
    end

    repeat (2) @(posedge clk);
    #1;
    check("exp_left", exp_i_q.size() + exp_d_q.size() + exp_cmd_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
